// File: rtl/uart_setpoint_pkg.sv
// rtl/uart_setpoint_pkg.sv - shared ASCII constants, parser state and axis types for the setpoint receiver.
package uart_setpoint_pkg;

  localparam logic [7:0] ASCII_D_LO  = 8'h64;
  localparam logic [7:0] ASCII_D_UP  = 8'h44;
  localparam logic [7:0] ASCII_Q_LO  = 8'h71;
  localparam logic [7:0] ASCII_Q_UP  = 8'h51;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, COMMIT} parser_state_t;

  typedef enum logic {AXIS_D, AXIS_Q} axis_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  function automatic logic is_sign(input logic [7:0] b);
    return (b == ASCII_PLUS) || (b == ASCII_MINUS);
  endfunction

  function automatic logic is_axis(input logic [7:0] b);
    return (b == ASCII_D_LO) || (b == ASCII_D_UP) || (b == ASCII_Q_LO) || (b == ASCII_Q_UP);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8-N-1 byte receiver with input synchronizer, glitch-rejecting start check and framing check.
module uart_rx_byte #(
  parameter logic [15:0] CLK_DIV = 16'd320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_ferr
);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [15:0] HALF = CLK_DIV >> 1;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic        r_ferr;

  logic w_tick_half;
  logic w_tick_full;

  assign w_tick_half = (r_cnt == HALF - 16'd1);
  assign w_tick_full = (r_cnt == CLK_DIV - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= 16'd0;
          if (!r_sync2 && r_prev) r_state <= RX_START;
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_tick_half) begin
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_tick_full) begin
            r_cnt   <= 16'd0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_tick_full) begin
            r_cnt <= 16'd0;
            if (r_sync2) begin
              r_valid <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_WAIT: begin
          // Resynchronise only after a full bit time of continuous idle-high line.
          if (!r_sync2) begin
            r_cnt <= 16'd0;
          end else if (w_tick_full) begin
            r_cnt   <= 16'd0;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_shift;
  assign o_ferr  = r_ferr;

endmodule

// File: rtl/uart_setpoint_rx.sv
// rtl/uart_setpoint_rx.sv - parses "<axis><sign>?<digits><term>" lines into clamped id/iq current setpoints.
module uart_setpoint_rx
  import uart_setpoint_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd320,
  parameter logic [15:0] LIMIT   = 16'd1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               o_en,
  output logic signed [15:0] o_id_aim,
  output logic signed [15:0] o_iq_aim,
  output logic               o_err
);

  logic       w_valid;
  logic [7:0] w_data;
  logic       w_ferr;

  uart_rx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx     (uart_rx),
    .o_valid(w_valid),
    .o_data (w_data),
    .o_ferr (w_ferr)
  );

  parser_state_t      r_state;
  axis_t              r_axis;
  logic               r_neg;
  logic [16:0]        r_acc;
  logic [2:0]         r_ndig;
  logic signed [15:0] r_id;
  logic signed [15:0] r_iq;
  logic               r_en;
  logic               r_err;

  logic [3:0]         w_digit;
  logic [16:0]        w_acc_next;
  logic [15:0]        w_mag;
  logic signed [15:0] w_value;

  assign w_digit    = w_data[3:0];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {13'd0, w_digit};

  always_comb begin
    w_mag = r_acc[15:0];
    if (r_acc > {1'b0, LIMIT}) w_mag = LIMIT;
    w_value = r_neg ? (16'd0 - w_mag) : w_mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_axis  <= AXIS_D;
      r_neg   <= 1'b0;
      r_acc   <= 17'd0;
      r_ndig  <= 3'd0;
      r_id    <= 16'sd0;
      r_iq    <= 16'sd0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ferr) begin
            r_err <= 1'b1;
          end else if (w_valid && is_axis(w_data)) begin
            r_state <= SIGN;
            r_axis  <= ((w_data == ASCII_D_LO) || (w_data == ASCII_D_UP)) ? AXIS_D : AXIS_Q;
            r_acc   <= 17'd0;
            r_neg   <= 1'b0;
            r_ndig  <= 3'd0;
          end
        end
        SIGN: begin
          if (w_ferr) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_valid) begin
            if (is_sign(w_data)) begin
              r_neg   <= (w_data == ASCII_MINUS);
              r_state <= DIGIT;
            end else if (is_digit(w_data)) begin
              r_acc   <= {13'd0, w_digit};
              r_ndig  <= 3'd1;
              r_state <= DIGIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        DIGIT: begin
          if (w_ferr) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (w_valid) begin
            if (is_digit(w_data) && (r_ndig != 3'd5)) begin
              r_acc  <= w_acc_next;
              r_ndig <= r_ndig + 3'd1;
            end else if (is_term(w_data) && (r_ndig != 3'd0)) begin
              r_state <= COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        COMMIT: begin
          // A framing error cannot land here: the next frame is still a bit-time away.
          if (r_axis == AXIS_D) r_id <= w_value;
          else                  r_iq <= w_value;
          r_en    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_en     = r_en;
  assign o_err    = r_err;
  assign o_id_aim = r_id;
  assign o_iq_aim = r_iq;

endmodule

// File: tb/tb_uart_setpoint_rx.sv
// tb/tb_uart_setpoint_rx.sv - self-checking bench for uart_setpoint_rx with a line-level command model.
module tb_uart_setpoint_rx;

  localparam int D = 24;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               uart_rx = 1'b1;
  logic               o_en;
  logic               o_err;
  logic signed [15:0] o_id_aim;
  logic signed [15:0] o_iq_aim;

  uart_setpoint_rx #(
    .CLK_DIV(16'(D)),
    .LIMIT  (16'd1000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .o_en    (o_en),
    .o_id_aim(o_id_aim),
    .o_iq_aim(o_iq_aim),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    bit is_en;
    int id;
    int iq;
  } ev_t;

  ev_t          exp_q[$];
  ev_t          cur;
  int           mm_id = 0;
  int           mm_iq = 0;
  int           m_id = 0;
  int           m_iq = 0;
  bit           in_cmd = 0;
  byte unsigned line_q[$];
  int           en_cnt = 0;
  int           err_cnt = 0;
  int           cyc = 0;
  int           last_in = 0;

  // Digits after the optional sign; -1 when the partial line can no longer be a command.
  function automatic int dig_count(input byte unsigned l[$]);
    int i = 1;
    int n = 0;
    if (l.size() > 1 && (l[1] == 8'h2B || l[1] == 8'h2D)) i = 2;
    for (int k = i; k < l.size(); k++) begin
      if (l[k] >= 8'h30 && l[k] <= 8'h39) n++;
      else return -1;
    end
    if (n > 5) return -1;
    return n;
  endfunction

  function automatic int line_value(input byte unsigned l[$]);
    int v = 0;
    int i = 1;
    if (l[1] == 8'h2B || l[1] == 8'h2D) i = 2;
    for (int k = i; k < l.size(); k++) v = v * 10 + (int'(l[k]) - 48);
    if (v > 1000) v = 1000;
    if (l[1] == 8'h2D) v = -v;
    return v;
  endfunction

  task automatic push_err();
    ev_t e;
    e.is_en = 1'b0;
    e.id = mm_id;
    e.iq = mm_iq;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input byte unsigned b, input bit good);
    ev_t e;
    if (!good) begin
      push_err();
      in_cmd = 0;
      line_q.delete();
      return;
    end
    if (!in_cmd) begin
      if (b == "d" || b == "D" || b == "q" || b == "Q") begin
        in_cmd = 1;
        line_q.delete();
        line_q.push_back(b);
      end
      return;
    end
    if (b == 8'h0A || b == 8'h0D) begin
      if (dig_count(line_q) >= 1) begin
        if (line_q[0] == "d" || line_q[0] == "D") mm_id = line_value(line_q);
        else mm_iq = line_value(line_q);
        e.is_en = 1'b1;
        e.id = mm_id;
        e.iq = mm_iq;
        exp_q.push_back(e);
      end else begin
        push_err();
      end
      in_cmd = 0;
      return;
    end
    line_q.push_back(b);
    if (dig_count(line_q) < 0) begin
      push_err();
      in_cmd = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    line_q.delete();
    in_cmd = 0;
    mm_id = 0;
    mm_iq = 0;
    m_id = 0;
    m_iq = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("en_err_exclusive", int'(o_en & o_err), 0);
      if (o_en) begin
        en_cnt++;
        chk("en_latency", cyc - last_in, 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_en", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("en_kind", int'(cur.is_en), 1);
          chk("id_on_en", int'(o_id_aim), cur.id);
          chk("iq_on_en", int'(o_iq_aim), cur.iq);
          m_id = cur.id;
          m_iq = cur.iq;
        end
      end else if (o_err) begin
        err_cnt++;
        chk("err_latency", cyc - last_in, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("err_kind", int'(cur.is_en), 0);
        end
      end else begin
        chk("id_hold", int'(o_id_aim), m_id);
        chk("iq_hold", int'(o_iq_aim), m_iq);
      end
      if (dut.u_rx.o_valid || dut.u_rx.o_ferr) last_in = cyc;
    end
  end

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_byte(input byte unsigned b, input bit good);
    model_byte(b, good);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good);
    if (!good) begin
      uart_rx = 1'b1;
      repeat (2 * D) @(negedge clk);
    end
    chk("events_drained", exp_q.size(), 0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  function automatic byte unsigned rand_axis();
    case ($urandom_range(0, 3))
      0: return "d";
      1: return "D";
      2: return "q";
      default: return "Q";
    endcase
  endfunction

  function automatic byte unsigned rand_digit();
    return 8'(8'h30 + $urandom_range(0, 9));
  endfunction

  function automatic byte unsigned rand_term();
    return ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
  endfunction

  int e0;
  int r0;

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_id", int'(o_id_aim), 0);
    chk("reset_iq", int'(o_iq_aim), 0);
    chk("reset_en", int'(o_en), 0);
    chk("reset_err", int'(o_err), 0);
    repeat (D) @(negedge clk);

    e0 = en_cnt; r0 = err_cnt;
    send_str("q-200\n");
    chk("t1_en_count", en_cnt - e0, 1);
    chk("t1_iq", int'(o_iq_aim), -200);
    chk("t1_id", int'(o_id_aim), 0);

    send_str("D+99999\r");
    chk("t2_id_clamped", int'(o_id_aim), 1000);
    send_str("d5\n");
    chk("t2_id", int'(o_id_aim), 5);
    chk("t2_iq_held", int'(o_iq_aim), -200);

    e0 = en_cnt; r0 = err_cnt;
    send_str("q12x\n");
    send_str("q\n");
    send_str("q123456\n");
    chk("t3_err_count", err_cnt - r0, 3);
    chk("t3_en_count", en_cnt - e0, 0);
    chk("t3_iq_held", int'(o_iq_aim), -200);

    e0 = en_cnt; r0 = err_cnt;
    send_str("q1");
    send_byte(8'h55, 1'b0);
    send_str("0\n");
    chk("t4_err_count", err_cnt - r0, 1);
    chk("t4_en_count", en_cnt - e0, 0);
    send_str("q7\n");
    chk("t4_iq", int'(o_iq_aim), 7);

    e0 = en_cnt; r0 = err_cnt;
    uart_rx = 1'b0;
    repeat (D / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    chk("t5_glitch_en", en_cnt - e0, 0);
    chk("t5_glitch_err", err_cnt - r0, 0);

    send_str("q3");
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    model_reset();
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (D) @(negedge clk);
    chk("t5_reset_id", int'(o_id_aim), 0);
    chk("t5_reset_iq", int'(o_iq_aim), 0);
    chk("t5_reset_en", en_cnt - e0, 0);
    chk("t5_reset_err", err_cnt - r0, 0);
    send_str("q300\n");
    chk("t5_iq", int'(o_iq_aim), 300);
    chk("t5_id", int'(o_id_aim), 0);

    e0 = en_cnt;
    send_str("q100\nq-100\n");
    chk("t6_en_count", en_cnt - e0, 2);
    chk("t6_iq", int'(o_iq_aim), -100);

    for (int n = 0; n < 25; n++) begin
      int kind;
      int nd;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_byte(rand_axis(), 1'b1);
        case ($urandom_range(0, 2))
          1: send_byte("+", 1'b1);
          2: send_byte("-", 1'b1);
          default: ;
        endcase
        nd = $urandom_range(1, 5);
        for (int k = 0; k < nd; k++) send_byte(rand_digit(), 1'b1);
        send_byte(rand_term(), 1'b1);
      end else if (kind == 6) begin
        send_byte(rand_axis(), 1'b1);
        nd = $urandom_range(0, 2);
        for (int k = 0; k < nd; k++) send_byte(rand_digit(), 1'b1);
        case ($urandom_range(0, 3))
          0: send_byte("x", 1'b1);
          1: send_byte(" ", 1'b1);
          2: send_byte(".", 1'b1);
          default: send_byte("q", 1'b1);
        endcase
        send_byte(rand_term(), 1'b1);
      end else if (kind == 7) begin
        send_byte(rand_axis(), 1'b1);
        if ($urandom_range(0, 1) == 1) send_byte("-", 1'b1);
        nd = ($urandom_range(0, 1) == 1) ? 6 : 0;
        for (int k = 0; k < nd; k++) send_byte(rand_digit(), 1'b1);
        send_byte(rand_term(), 1'b1);
      end else if (kind == 8) begin
        nd = $urandom_range(1, 3);
        for (int k = 0; k < nd; k++) begin
          case ($urandom_range(0, 6))
            0: send_byte(" ", 1'b1);
            1: send_byte("z", 1'b1);
            2: send_byte("1", 1'b1);
            3: send_byte("-", 1'b1);
            4: send_byte(8'h0D, 1'b1);
            5: send_byte(8'h0A, 1'b1);
            default: send_byte("x", 1'b1);
          endcase
        end
        send_byte(rand_axis(), 1'b1);
        nd = $urandom_range(1, 3);
        for (int k = 0; k < nd; k++) send_byte(rand_digit(), 1'b1);
        send_byte(rand_term(), 1'b1);
      end else begin
        send_byte(rand_axis(), 1'b1);
        send_byte(rand_digit(), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte("5", 1'b1);
        send_byte(8'h0A, 1'b1);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, D)) @(negedge clk);
    end

    repeat (2 * D) @(negedge clk);
    chk("final_events_drained", exp_q.size(), 0);
    chk("final_id", int'(o_id_aim), mm_id);
    chk("final_iq", int'(o_iq_aim), mm_iq);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_setpoint_rx.md
# uart_setpoint_rx

Receives ASCII current-setpoint commands over a 115200-8-N-1 UART line and drives the `id_aim` / `iq_aim` inputs of `foc_top`, replacing the fixed square-wave `iq_aim` generator. It sits directly upstream of `foc_top` and is the receive-side counterpart of `uart_monitor`. Commands are parsed, saturated to a configurable limit, and committed atomically per line.

## Interface
- `CLK_DIV`, 16'd320: clock cycles per UART bit. 36.864 MHz / 320 = 115200 baud.
- `LIMIT`, 16'd1000: maximum setpoint magnitude. Committed values are clamped to ±LIMIT. Must be ≤ 32767.
- `clk` input, 1 bit: system clock, the same `clk` used by `foc_top`.
- `rst` input, 1 bit: reset. Synchronous and active-high.
- `uart_rx` input, 1 bit: asynchronous UART line, idle high.
- `o_en` output, 1 bit: one-cycle pulse when `o_id_aim` or `o_iq_aim` has just changed.
- `o_id_aim` output, signed 16 bits: d-axis current setpoint.
- `o_iq_aim` output, signed 16 bits: q-axis current setpoint.
- `o_err` output, 1 bit: one-cycle pulse when a line is rejected.

## Operation
- Command grammar, one command per line: `<axis><sign>?<digits><term>`.
  - axis is `d`/`D` or `q`/`Q`.
  - sign is `+` or `-`.
  - digits is 1 to 5 of `0`-`9`.
  - term is LF (0x0A) or CR (0x0D).
- Byte receiver:
  - 2-flop synchronizer on `uart_rx`.
  - A falling edge in idle starts a frame.
  - The start bit is re-checked at CLK_DIV/2. If it reads high, the frame is discarded silently as a glitch.
  - Data bits are sampled every CLK_DIV thereafter, LSB first.
  - The stop bit is sampled at mid-bit. Stop = 0 is a framing error: the byte is dropped, `o_err` pulses, and the receiver waits until the line has been high for one full bit before accepting a new start bit.
- Parser FSM states:
  - `IDLE`:
    - axis char → `SIGN`, latches the axis, clears the accumulator, sets sign to positive.
    - CR, LF, space and all other bytes are ignored.
  - `SIGN`:
    - `-` or `+` → `DIGIT`, records the sign.
    - A digit → `DIGIT` and accumulates that digit.
    - Anything else → error.
  - `DIGIT`:
    - A digit updates the accumulator: acc = acc*10 + d. The accumulator is 17 bits unsigned, max 99999.
    - A terminator with at least 1 digit → `COMMIT`.
    - A 6th digit, a terminator with 0 digits, or any other char → error.
  - `COMMIT` (one cycle):
    - mag = min(acc, LIMIT); the value is −mag if negative, else mag.
    - Writes the selected output register and pulses `o_en`. Then → `IDLE`.
  - Error: pulses `o_err`, → `IDLE`, and no output changes.
- A framing error while in `SIGN` or `DIGIT` aborts the line: one `o_err` pulse total and → `IDLE`.
- `-0` commits 0. `+` is accepted.
- Only the addressed axis register changes. The other axis holds its value.

## Timing
- Reset values: `o_id_aim` = 0, `o_iq_aim` = 0, `o_en` = 0, `o_err` = 0. Parser → `IDLE`, receiver → idle.
- Reset mid-frame or mid-line abandons all partial state. No `o_en` or `o_err` pulse is generated by the reset.
- A received byte is valid one cycle after the mid-stop-bit sample. The parser consumes it in that same cycle.
- Terminator byte valid → `COMMIT` on the next cycle. The new value and `o_en` both appear on the cycle after `COMMIT` (registered outputs). Latency is 2 cycles from the terminator byte being valid.
- `o_err` is registered and appears 1 cycle after the offending byte is valid (or after the framing error is detected).
- `o_en` and `o_err` are never high in the same cycle.
- Back-to-back bytes at full line rate: the parser is ready again within 3 cycles, which is far less than one 10-bit frame, so no buffering is needed.

## Structure
- Package `uart_setpoint_pkg`:
  - ASCII constants for `d`, `D`, `q`, `Q`, `+`, `-`, `0`, `9`, CR, LF.
  - Parser state enum `{IDLE, SIGN, DIGIT, COMMIT}`.
  - The axis select type.
- Sub-module `uart_rx_byte` (parameter `CLK_DIV`; ports `clk`, `rst`, `rx`, `o_valid`, `o_data[7:0]`, `o_ferr`) holds the synchronizer, bit timer and framing check.
- The parser, clamp and output registers live in `uart_setpoint_rx`.
- The multiply-by-10 is implemented as (acc<<3)+(acc<<1). No DSP is required.

## Test plan
- Send `q-200\n` → exactly one `o_en` pulse, `o_iq_aim` = −200, `o_id_aim` stays 0, `o_en` asserted 2 cycles after the LF byte is valid.
- With LIMIT = 1000, send `D+99999\r` → `o_id_aim` = +1000. Then send `d5\n` → `o_id_aim` = 5, `o_iq_aim` unchanged.
- Send `q12x\n`, `q\n`, then `q123456\n` → three `o_err` pulses, no `o_en`, `o_iq_aim` unchanged.
- Send a byte with stop bit = 0 mid-line (`q1`, bad frame, `0\n`) → one `o_err`, and `0\n` is ignored in `IDLE`. A following `q7\n` yields `o_iq_aim` = 7.
- 1/4-bit low glitch on `uart_rx` → no byte received, no pulses. Assert `rst` mid-byte of `q300\n`, then resend `q300\n` → outputs 0 after reset, then `o_iq_aim` = 300.
- Stream `q100\nq-100\n` back-to-back with no idle gap → two `o_en` pulses, with final `o_iq_aim` = −100.
